// File: rtl/skywave_rst_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Exports: rst_state_t (sequencer FSM), rst_cause_t (reset cause encoding),
//          RST_MAX_STAGES, cnt_width() helper for sizing down-counters.
package skywave_rst_pkg;

  typedef enum logic [1:0] {
    RST_ASSERT,
    RST_RELEASE,
    RST_RUN
  } rst_state_t;

  typedef enum logic [1:0] {
    RST_CAUSE_POR = 2'd0,
    RST_CAUSE_SW  = 2'd1,
    RST_CAUSE_WDT = 2'd2
  } rst_cause_t;

  localparam int RST_MAX_STAGES = 8;

  // Bits needed to hold max_val-1 (a down-counter loaded with max_val-1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/skywave_rst_timer.sv
// Loadable down-counter with a done flag; saturates at zero.
// Latency: load/decrement take effect at the next clk edge; done is combinational on the count.
// Backpressure: none; en simply pauses counting.
// Ports: clk, reset_n (sync, active-low, clears count), load + load_val (priority over en),
//        en (decrement while nonzero), done (count == 0).
module skywave_rst_timer
  import skywave_rst_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/skywave_rst_seq.sv
// Staged reset sequencer: holds all stage resets, then releases them in order
// (stage 0 first), services rising-edge software reset requests, reports last cause.
// Latency: stage k releases HOLD_CYCLES+k*STAGE_DELAY edges after the sequence start.
// Backpressure: none; requests outside RUN are dropped, not queued.
// Ports: clk_i, reset_i (sync, active-low), swrst_req_i / swrst_ack_o, wdt_kick_i,
//        stage_rst_o[NUM_STAGES] (active-high), ready_o, rst_cause_o.
// Build option: define SKYWAVE_RST_WDT_EN to add the watchdog (WDT_TIMEOUT cycles).
module skywave_rst_seq
  import skywave_rst_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 16,
  parameter int WDT_TIMEOUT = 2**20
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  swrst_req_i,
  output logic                  swrst_ack_o,
  input  logic                  wdt_kick_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  ready_o,
  output logic [1:0]            rst_cause_o
);

  if (NUM_STAGES < 1 || NUM_STAGES > RST_MAX_STAGES) begin : g_bad_stages
    $error("skywave_rst_seq: NUM_STAGES must be 1..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("skywave_rst_seq: HOLD_CYCLES must be >= 1");
  end
  if (STAGE_DELAY < 1) begin : g_bad_delay
    $error("skywave_rst_seq: STAGE_DELAY must be >= 1");
  end

  localparam int TW = cnt_width((HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY);
  localparam int IW = $clog2(RST_MAX_STAGES + 1);

  rst_state_t            state_q, state_d;
  rst_cause_t            cause_q, cause_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic [IW-1:0]         idx_q, idx_d;      // number of stages released so far
  logic                  armed_q, armed_d;  // hold timer loaded for this ASSERT pass
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  req_q;
  logic                  req_rise;
  logic                  tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]         tmr_val;
  logic                  wdt_fire;
  logic                  all_released;

  assign req_rise     = swrst_req_i & ~req_q;
  assign all_released = (idx_q == IW'(NUM_STAGES));

  skywave_rst_timer #(.WIDTH(TW)) u_stage_tmr (
    .clk      (clk_i),
    .reset_n  (reset_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

`ifdef SKYWAVE_RST_WDT_EN
  localparam int WW = cnt_width(WDT_TIMEOUT);
  logic wdt_done;
  logic wdt_load;

  // Reload on RUN entry and on every kick; counts only while in RUN.
  assign wdt_load = (state_q == RST_RELEASE && all_released) ||
                    (state_q == RST_RUN && wdt_kick_i);
  // A kick in the expiry cycle wins over the timeout.
  assign wdt_fire = (state_q == RST_RUN) && wdt_done && !wdt_kick_i;

  skywave_rst_timer #(.WIDTH(WW)) u_wdt_tmr (
    .clk      (clk_i),
    .reset_n  (reset_i),
    .load     (wdt_load),
    .load_val (WW'(WDT_TIMEOUT - 1)),
    .en       (state_q == RST_RUN),
    .done     (wdt_done)
  );
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick_i;
  assign wdt_fire        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    stage_rst_d = stage_rst_q;
    idx_d       = idx_q;
    armed_d     = armed_q;
    ready_d     = ready_q;
    ack_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_en      = 1'b0;

    case (state_q)
      RST_ASSERT: begin
        // First cycle of a pass loads the hold count; done then marks its expiry.
        if (!armed_q) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYCLES - 1);
          armed_d  = 1'b1;
        end else if (tmr_done) begin
          stage_rst_d[0] = 1'b0;
          idx_d          = IW'(1);
          armed_d        = 1'b0;
          tmr_load       = 1'b1;
          tmr_val        = TW'(STAGE_DELAY - 1);
          state_d        = RST_RELEASE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      RST_RELEASE: begin
        if (all_released) begin
          ready_d = 1'b1;
          state_d = RST_RUN;
        end else if (tmr_done) begin
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IW'(k)) stage_rst_d[k] = 1'b0;
          end
          idx_d    = idx_q + IW'(1);
          tmr_load = 1'b1;
          tmr_val  = TW'(STAGE_DELAY - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end

      RST_RUN: begin
        if (req_rise || wdt_fire) begin
          ack_d       = req_rise;
          cause_d     = req_rise ? RST_CAUSE_SW : RST_CAUSE_WDT;
          stage_rst_d = '1;
          ready_d     = 1'b0;
          idx_d       = '0;
          armed_d     = 1'b0;
          state_d     = RST_ASSERT;
        end
      end

      default: begin
        state_d = RST_ASSERT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= RST_ASSERT;
      cause_q     <= RST_CAUSE_POR;
      stage_rst_q <= '1;
      idx_q       <= '0;
      armed_q     <= 1'b0;
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      stage_rst_q <= stage_rst_d;
      idx_q       <= idx_d;
      armed_q     <= armed_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      req_q       <= swrst_req_i;
    end
  end

  assign stage_rst_o = stage_rst_q;
  assign ready_o     = ready_q;
  assign swrst_ack_o = ack_q;
  assign rst_cause_o = cause_q;

endmodule
